// File: rtl/stream_mux_pkg.sv
// Shared defaults and the channel-index width helper for the N:1 stream mux.
package stream_mux_pkg;
  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 8;

  // Index width never drops below one bit, so N=1 still has a legal port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, one-hot grant.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    // Scan ptr+1 .. ptr+N so the last winner has the lowest priority.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N:1 valid/ready stream mux, round-robin or forced channel, one-slot output.
// Define STREAM_MUX_LOCK_EN to hold the grant on a channel until its I_LAST beat.
module stream_mux_nx1
  import stream_mux_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = sel_w(N)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N*DATA_W-1:0] I_DATA,
  input  logic [N-1:0]        I_VALID,
  output logic [N-1:0]        I_READY,
  input  logic [N-1:0]        I_LAST,
  input  logic                FORCE_EN,
  input  logic [SEL_W-1:0]    FORCE_SEL,
  output logic [DATA_W-1:0]   Y,
  output logic                Y_VALID,
  input  logic                Y_READY,
  output logic                Y_LAST,
  output logic [SEL_W-1:0]    Y_CH
);

  logic              ld, xfer;
  logic [SEL_W-1:0]  ptr, g_idx;
  logic [N-1:0]      cand, grant;
  logic [DATA_W-1:0] g_data;
  logic              g_last;

`ifdef STREAM_MUX_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_ch;
`endif

  assign ld = !Y_VALID || Y_READY;

  // Candidate set: locked channel, else forced channel, else everyone.
  always_comb begin
    cand = '1;
`ifdef STREAM_MUX_LOCK_EN
    if (lock) begin
      for (int k = 0; k < N; k++) cand[k] = (int'(lock_ch) == k);
    end else
`endif
    if (FORCE_EN) begin
      for (int k = 0; k < N; k++) cand[k] = (int'(FORCE_SEL) == k);
    end
  end

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req   (I_VALID & cand),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    g_idx  = '0;
    g_data = '0;
    g_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        g_idx  = SEL_W'(i);
        g_data = I_DATA[i*DATA_W +: DATA_W];
        g_last = I_LAST[i];
      end
    end
  end

  assign I_READY = (RST || !ld) ? '0 : grant;
  assign xfer    = |I_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      Y       <= '0;
      Y_VALID <= 1'b0;
      Y_LAST  <= 1'b0;
      Y_CH    <= '0;
      ptr     <= SEL_W'(N - 1);
    end else if (ld) begin
      Y_VALID <= xfer;
      if (xfer) begin
        Y      <= g_data;
        Y_LAST <= g_last;
        Y_CH   <= g_idx;
        ptr    <= g_idx;
      end
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      lock    <= !g_last;
      lock_ch <= g_idx;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Self-checking bench for stream_mux_nx1: directed scenarios plus randomized
// traffic against a per-transfer behavioural model.
module tb_stream_mux_nx1;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N*DW-1:0] I_DATA;
  logic [N-1:0]    I_VALID, I_READY, I_LAST;
  logic            FORCE_EN;
  logic [SW-1:0]   FORCE_SEL;
  logic [DW-1:0]   Y;
  logic            Y_VALID, Y_READY, Y_LAST;
  logic [SW-1:0]   Y_CH;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int       m_ptr, m_ch, m_lock_ch, last_g;
  bit       m_lock, m_yv, m_last;
  bit [7:0] m_y;

  stream_mux_nx1 #(.N(N), .DATA_W(DW), .SEL_W(SW)) dut (
    .CLK(CLK), .RST(RST), .I_DATA(I_DATA), .I_VALID(I_VALID), .I_READY(I_READY),
    .I_LAST(I_LAST), .FORCE_EN(FORCE_EN), .FORCE_SEL(FORCE_SEL), .Y(Y),
    .Y_VALID(Y_VALID), .Y_READY(Y_READY), .Y_LAST(Y_LAST), .Y_CH(Y_CH)
  );

  always #5 CLK = ~CLK;

  // Winning channel under the current inputs, or -1 if nobody may go.
  function automatic int model_grant();
    bit ok;
    int ch;
    if (RST) return -1;
    for (int k = 1; k <= N; k++) begin
      ch = (m_ptr + k) % N;
      if (m_lock)        ok = (ch == m_lock_ch);
      else if (FORCE_EN) ok = (ch == int'(FORCE_SEL));
      else               ok = 1'b1;
      if (ok && I_VALID[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0 && (!m_yv || Y_READY)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    int g;
    bit ld;
    g  = model_grant();
    ld = !m_yv || Y_READY;
    last_g = -1;
    @(posedge CLK);
    if (RST) begin
      m_yv = 0; m_y = 0; m_last = 0; m_ch = 0; m_ptr = N - 1; m_lock = 0; m_lock_ch = 0;
    end else if (ld) begin
      if (g >= 0) begin
        m_y = I_DATA[g*DW +: DW]; m_last = I_LAST[g]; m_ch = g; m_yv = 1; m_ptr = g;
        last_g = g;
`ifdef STREAM_MUX_LOCK_EN
        m_lock = !I_LAST[g]; m_lock_ch = g;
`endif
      end else m_yv = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1; I_VALID = '0; I_LAST = '0; I_DATA = '0; FORCE_EN = 0; FORCE_SEL = '0; Y_READY = 1;
    tick(); tick();
    RST = 0;
  endtask

  task automatic test_reset();
    RST = 1; I_VALID = '1; I_DATA = $urandom; I_LAST = '0; Y_READY = 1; FORCE_EN = 0; FORCE_SEL = '0;
    tick(); tick();
    n_tests++; if (Y_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_yvalid: got %b want 0", Y_VALID); end
    n_tests++; if (Y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h want 00", Y); end
    n_tests++; if (Y_CH !== 3'd0) begin n_fail++; $display("FAIL reset_ych: got %0d want 0", Y_CH); end
    n_tests++; if (I_READY !== 4'b0000) begin n_fail++; $display("FAIL reset_iready: got %b want 0000", I_READY); end
    RST = 0;
  endtask

  task automatic test_fairness();
    do_reset();
    I_DATA = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; I_VALID = 4'b1111; I_LAST = '1; Y_READY = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (Y_VALID !== 1'b1 || Y_CH !== SW'(i % 4) || Y !== 8'hA0 + 8'(i % 4)) begin
        n_fail++; $display("FAIL fairness[%0d]: got v=%b ch=%0d y=%h want v=1 ch=%0d y=%h",
                           i, Y_VALID, Y_CH, Y, i % 4, 8'hA0 + 8'(i % 4));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    I_VALID = 4'b0001; I_DATA = {24'h0, 8'h55}; Y_READY = 1;
    tick();
    n_tests++; if (Y !== 8'h55 || Y_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_load: got y=%h v=%b want 55/1", Y, Y_VALID); end
    Y_READY = 0; I_DATA = {8'h69, 8'h68, 8'h67, 8'h66}; I_VALID = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (I_READY !== 4'b0000) begin n_fail++; $display("FAIL bp_iready[%0d]: got %b want 0000", i, I_READY); end
      tick();
      n_tests++; if (Y !== 8'h55 || Y_CH !== 3'd0 || Y_VALID !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got y=%h ch=%0d v=%b want 55/0/1", i, Y, Y_CH, Y_VALID);
      end
    end
    Y_READY = 1; I_VALID = 4'b0001;
    #1;
    n_tests++; if (I_READY !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0001", I_READY); end
    tick();
    n_tests++; if (Y !== 8'h66 || Y_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_release: got y=%h v=%b want 66/1", Y, Y_VALID); end
  endtask

  task automatic test_force();
    logic [7:0] exp_d;
    do_reset();
    FORCE_EN = 1; FORCE_SEL = 3'd2; I_VALID = 4'b1111; Y_READY = 1;
    for (int i = 0; i < 4; i++) begin
      I_DATA = $urandom; exp_d = I_DATA[23:16];
      #1;
      n_tests++; if (I_READY !== 4'b0100) begin n_fail++; $display("FAIL force_ready[%0d]: got %b want 0100", i, I_READY); end
      tick();
      n_tests++; if (Y_CH !== 3'd2 || Y !== exp_d) begin n_fail++; $display("FAIL force_beat[%0d]: got ch=%0d y=%h want 2/%h", i, Y_CH, Y, exp_d); end
    end
    FORCE_SEL = 3'd5;
    #1;
    n_tests++; if (I_READY !== 4'b0000) begin n_fail++; $display("FAIL force_oob_ready: got %b want 0000", I_READY); end
    tick();
    n_tests++; if (Y_VALID !== 1'b0) begin n_fail++; $display("FAIL force_oob_valid: got %b want 0", Y_VALID); end
    FORCE_EN = 0;
  endtask

  task automatic test_lock();
    int beat;
    int exp_ch [4];
`ifdef STREAM_MUX_LOCK_EN
    exp_ch = '{1, 1, 1, 0};
`else
    exp_ch = '{1, 0, 1, 0};
`endif
    do_reset();
    beat = 0; I_VALID = 4'b0010; I_LAST = 4'b0001; Y_READY = 1;
    for (int i = 0; i < 4; i++) begin
      I_LAST[1] = (beat == 2);
      I_DATA    = {16'h0, 8'hB0 + 8'(beat), 8'hC0};
      tick();
      n_tests++; if (Y_CH !== SW'(exp_ch[i]) || Y_CH !== SW'(m_ch)) begin
        n_fail++; $display("FAIL lock_seq[%0d]: got ch=%0d want %0d", i, Y_CH, exp_ch[i]);
      end
      if (last_g == 1) beat++;
      I_VALID = 4'b0011;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    I_VALID = 4'b0010; I_LAST = 4'b0000; I_DATA = {16'h0, 8'hB1, 8'hC7}; Y_READY = 1;
    tick(); tick();
    I_VALID = 4'b0011; RST = 1;
    #1;
    n_tests++; if (I_READY !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0000", I_READY); end
    tick();
    n_tests++; if (Y_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard: got v=%b want 0", Y_VALID); end
    RST = 0;
    tick();
    n_tests++; if (Y_CH !== 3'd0 || Y !== 8'hC7 || Y_VALID !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_first: got ch=%0d y=%h v=%b want 0/c7/1", Y_CH, Y, Y_VALID);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_r;
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      I_VALID   = N'($urandom);
      I_DATA    = $urandom;
      I_LAST    = N'($urandom);
      Y_READY   = ($urandom_range(0, 3) != 0);
      FORCE_EN  = ($urandom_range(0, 7) == 0);
      FORCE_SEL = SW'($urandom_range(0, 5));
      RST       = ($urandom_range(0, 49) == 0);
      #1;
      exp_r = model_ready();
      if (RST || model_grant() >= 0) begin
        n_tests++; if (I_READY !== exp_r) begin
          n_fail++; errs++; if (errs < 10) $display("FAIL rand_ready[%0d]: got %b want %b", i, I_READY, exp_r);
        end
      end
      tick();
      n_tests++; if (Y_VALID !== m_yv || Y !== m_y || Y_CH !== SW'(m_ch) || Y_LAST !== m_last) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_out[%0d]: got v=%b y=%h ch=%0d l=%b want v=%b y=%h ch=%0d l=%b",
                                i, Y_VALID, Y, Y_CH, Y_LAST, m_yv, m_y, m_ch, m_last);
      end
    end
    RST = 0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_force();
    test_lock();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_nx1.md
STREAM_MUX_NX1 -- requirements
Module: stream_mux_nx1

Interface
REQ-001 Parameter N, default 4, number of input channels; SHALL be at least 1.
REQ-002 Parameter DATA_W, default 8, data bits per channel.
REQ-003 Parameter SEL_W, default max(1, clog2(N)), channel index width.
REQ-004 CLK  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 I_DATA  in  N*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 I_VALID  in  N  per-channel beat valid.
REQ-008 I_READY  out  N  per-channel beat accept; combinational.
REQ-009 I_LAST  in  N  per-channel end-of-packet marker.
REQ-010 FORCE_EN  in  1  restricts selection to the channel on FORCE_SEL (classic mux mode).
REQ-011 FORCE_SEL  in  SEL_W  forced channel index.
REQ-012 Y  out  DATA_W  registered output data.
REQ-013 Y_VALID  out  1  output beat valid.
REQ-014 Y_READY  in  1  downstream accept.
REQ-015 Y_LAST  out  1  registered copy of the accepted beat's I_LAST.
REQ-016 Y_CH  out  SEL_W  source channel of the beat on Y.

Function
REQ-017 Output stage SHALL be a single register slot; load enable LD = !Y_VALID or Y_READY.
REQ-018 Exactly one candidate channel g SHALL be granted per cycle; I_READY[g] = LD, all other I_READY bits 0.
REQ-019 Beat transfer occurs when I_VALID[g] and I_READY[g]; Y, Y_LAST, Y_CH load next edge, Y_VALID=1; latency 1 cycle.
REQ-020 LD with no transfer SHALL clear Y_VALID; Y, Y_LAST, Y_CH hold.
REQ-021 While Y_VALID and !Y_READY, Y, Y_LAST and Y_CH SHALL stay stable.
REQ-022 Arbitration: round-robin over valid channels starting at PTR+1 modulo N; PTR updates to g on each transfer.
REQ-023 FORCE_EN=1: only channel FORCE_SEL is candidate; FORCE_SEL >= N grants nothing (all I_READY 0).
REQ-024 Throughput SHALL be one beat per cycle with Y_READY held high.
REQ-025 N=1: channel 0 always candidate; PTR is a constant.

Reset
REQ-026 RST SHALL set Y_VALID=0, Y=0, Y_LAST=0, Y_CH=0, PTR=N-1 (channel 0 first) and clear the lock.
REQ-027 RST mid-packet or with Y_VALID=1 SHALL discard the held beat; all I_READY 0 while RST high.

Configuration
REQ-028 Macro STREAM_MUX_LOCK_EN defined: after a transfer from g with I_LAST[g]=0, grant stays on g until a beat with I_LAST[g]=1 transfers; FORCE_EN sampled only at packet boundaries.
REQ-029 Macro undefined: arbitration per beat; I_LAST only passed through to Y_LAST.

Structure
REQ-030 Package stream_mux_pkg SHALL hold default N, DATA_W and a clog2-based SEL_W helper.
REQ-031 Sub-module rr_arbiter (N-bit request, PTR in, one-hot grant out, combinational) SHALL implement REQ-022/023.

Verification
REQ-032 Reset: RST=1 two cycles, all I_VALID=1 -> Y_VALID=0, Y=0, I_READY=4'b0000.
REQ-033 Fairness: I_VALID=4'b1111, data 8'hA0..8'hA3, Y_READY=1 -> Y_CH 0,1,2,3,0 on consecutive cycles, Y=8'hA0,A1,A2,A3,A0.
REQ-034 Backpressure: Y holds 8'h55, Y_READY=0 three cycles -> Y/Y_CH stable, I_READY=0; Y_READY=1 -> next beat next cycle.
REQ-035 Force mode: FORCE_EN=1, FORCE_SEL=2, I_VALID=4'b1111 -> only I_READY[2]=1, Y_CH=2 every beat; FORCE_SEL=5 with N=4 -> no grant, Y_VALID drops.
REQ-036 Lock (macro on): ch1 3-beat packet (LAST on beat 3), ch0 valid throughout -> Y_CH=1,1,1 then 0; macro off -> Y_CH alternates 1,0,1,0.
REQ-037 Reset mid-packet (macro on): RST after beat 2 of ch1 -> lock cleared, first post-reset grant is channel 0.
